// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe register chain.
package pipe_pkg;

    // Width needed to count 0..depth occupied stages.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the chain: a valid bit plus a data word.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int CLEAR_DATA = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ld,
    input  logic             in_vld,
    input  logic [DSIZE-1:0] in_data,
    output logic             vld,
    output logic [DSIZE-1:0] data
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (flush) begin
            vld <= 1'b0;
            if (CLEAR_DATA != 0) data <= '0;
        end else if (ld) begin
            vld <= in_vld;
            if (in_vld) begin
                data <= in_data;
            end else if (CLEAR_DATA != 0) begin
                data <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Bubble-collapsing register pipeline with backpressure, occupancy count and
// sticky overflow flag.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int DEPTH      = 4,
    parameter int CLEAR_DATA = 1
) (
    input  logic                             clock,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [DSIZE-1:0]                 indata,
    input  logic                             flush,
    input  logic                             low_empty,
    output logic                             high_reload,
    output logic                             valid,
    output logic [DSIZE-1:0]                 outdata,
    output logic                             curr_empty,
    output logic                             sum_empty,
    output logic [count_width(DEPTH)-1:0]    count,
    output logic                             overflow
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] ld;
    logic [DSIZE-1:0] data [DEPTH];
    logic             push;
    logic             pop;

    // A stage advances when any stage downstream of it is empty or the
    // output word is taken; unrolled from the output end to avoid a
    // self-referencing vector.
    always_comb begin
        logic run;
        run = low_empty;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = run;
            run    = run | ~vld[i];
        end
    end

    assign ld = ~vld | adv;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            pipe_stage #(
                .DSIZE      (DSIZE),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_stage (
                .clock   (clock),
                .rst_n   (rst_n),
                .flush   (flush),
                .ld      (ld[i]),
                .in_vld  (wr_en),
                .in_data (indata),
                .vld     (vld[i]),
                .data    (data[i])
            );
        end else begin : g_body
            pipe_stage #(
                .DSIZE      (DSIZE),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_stage (
                .clock   (clock),
                .rst_n   (rst_n),
                .flush   (flush),
                .ld      (ld[i]),
                .in_vld  (vld[i-1]),
                .in_data (data[i-1]),
                .vld     (vld[i]),
                .data    (data[i])
            );
        end
    end

    assign high_reload = ld[0];
    assign valid       = vld[DEPTH-1];
    assign outdata     = data[DEPTH-1];
    assign curr_empty  = ~vld[DEPTH-1];
    assign sum_empty   = ~|vld;

    assign push = wr_en & ld[0];
    assign pop  = vld[DEPTH-1] & low_empty;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (!push && pop) begin
            count <= count - CW'(1);
        end
    end

    // Flush drops the write silently rather than counting it as lost.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (!flush && wr_en && !ld[0]) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: vector table, corner sequences and
// randomized traffic against a queue-of-words model.
module tb_pipe_reg_chain;

    localparam int DSIZE = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [DSIZE-1:0] indata = '0;
    logic             flush = 1'b0;
    logic             low_empty = 1'b0;
    logic             high_reload;
    logic             valid;
    logic [DSIZE-1:0] outdata;
    logic             curr_empty;
    logic             sum_empty;
    logic [CW-1:0]    count;
    logic             overflow;

    pipe_reg_chain #(
        .DSIZE      (DSIZE),
        .DEPTH      (DEPTH),
        .CLEAR_DATA (1)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .indata      (indata),
        .flush       (flush),
        .low_empty   (low_empty),
        .high_reload (high_reload),
        .valid       (valid),
        .outdata     (outdata),
        .curr_empty  (curr_empty),
        .sum_empty   (sum_empty),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: queued words with their stage position (0 = input end).
    typedef int iq_t[$];
    int mq[$];
    int mp[$];
    bit movf;

    function automatic bit model_pops(input bit le);
        return mp.size() > 0 && mp[0] == DEPTH - 1 && le;
    endfunction

    function automatic iq_t model_advance(input bit le);
        iq_t np;
        int  lim;
        np = mp;
        if (model_pops(le)) void'(np.pop_front());
        lim = DEPTH - 1;
        foreach (np[k]) begin
            if (np[k] < lim) np[k]++;
            lim = np[k] - 1;
        end
        return np;
    endfunction

    function automatic bit model_ready(input bit le);
        iq_t np;
        np = model_advance(le);
        return np.size() == 0 || np[np.size()-1] > 0;
    endfunction

    task automatic model_step(input bit w, input int d, input bit f, input bit le);
        bit  rdy;
        iq_t np;
        if (f) begin
            mq.delete();
            mp.delete();
        end else begin
            rdy = model_ready(le);
            np  = model_advance(le);
            if (model_pops(le)) void'(mq.pop_front());
            mp = np;
            if (w) begin
                if (rdy) begin
                    mq.push_back(d);
                    mp.push_back(0);
                end else begin
                    movf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        bit v;
        v = mp.size() > 0 && mp[0] == DEPTH - 1;
        chk("rnd_high_reload", high_reload, model_ready(low_empty));
        chk("rnd_valid", valid, v);
        chk("rnd_outdata", outdata, v ? mq[0] : 0);
        chk("rnd_count", count, mq.size());
        chk("rnd_sum_empty", sum_empty, mq.size() == 0);
        chk("rnd_curr_empty", curr_empty, !v);
        chk("rnd_overflow", overflow, movf);
    endtask

    task automatic drive(input bit w, input int d, input bit f, input bit l);
        @(negedge clock);
        wr_en     = w;
        indata    = d[DSIZE-1:0];
        flush     = f;
        low_empty = l;
    endtask

    // Apply one cycle of inputs and sample just after the active edge.
    task automatic cycle(input bit w, input int d, input bit f, input bit l);
        drive(w, d, f, l);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        wr_en = 1'b0;
        indata = '0;
        flush = 1'b0;
        low_empty = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        mq.delete();
        mp.delete();
        movf = 1'b0;
    endtask

    typedef struct {
        bit wr; int d; bit fl; bit le;
        bit hr; bit v; int o; int c; bit ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Streaming: 0x01..0x08 then drain.
        for (int k = 0; k < 8; k++) begin
            tbl.push_back('{1, k + 1, 0, 1, 1, k >= 3, (k >= 3) ? k - 2 : 0,
                            (k < 3) ? k + 1 : 4, 0});
        end
        tbl.push_back('{0, 0, 0, 1, 1, 1, 8'h06, 3, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 1, 8'h07, 2, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 1, 8'h08, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 0, 8'h00, 0, 0});
        // Backpressure: only 0xA0..0xA3 fit.
        tbl.push_back('{1, 8'hA0, 0, 0, 1, 0, 8'h00, 1, 0});
        tbl.push_back('{1, 8'hA1, 0, 0, 1, 0, 8'h00, 2, 0});
        tbl.push_back('{1, 8'hA2, 0, 0, 1, 0, 8'h00, 3, 0});
        tbl.push_back('{1, 8'hA3, 0, 0, 0, 1, 8'hA0, 4, 0});
        tbl.push_back('{1, 8'hA4, 0, 0, 0, 1, 8'hA0, 4, 1});
        tbl.push_back('{1, 8'hA5, 0, 0, 0, 1, 8'hA0, 4, 1});
        // Full chain: write and pop together.
        tbl.push_back('{1, 8'h55, 0, 1, 1, 1, 8'hA1, 4, 1});

        do_reset();
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_outdata", outdata, 0);
        chk("rst_curr_empty", curr_empty, 1);
        chk("rst_sum_empty", sum_empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_high_reload", high_reload, 1);

        foreach (tbl[i]) begin
            cycle(tbl[i].wr, tbl[i].d, tbl[i].fl, tbl[i].le);
            chk($sformatf("vec%0d_high_reload", i), high_reload, tbl[i].hr);
            chk($sformatf("vec%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("vec%0d_outdata", i), outdata, tbl[i].o);
            chk($sformatf("vec%0d_count", i), count, tbl[i].c);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
        end

        // Bubble collapse.
        do_reset();
        cycle(1, 8'h11, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 8'h22, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
        chk("bubble_count", count, 2);
        chk("bubble_valid", valid, 1);
        chk("bubble_outdata", outdata, 8'h11);
        cycle(0, 0, 0, 1);
        chk("bubble_next_out", outdata, 8'h22);
        chk("bubble_next_count", count, 1);
        cycle(0, 0, 0, 1);
        chk("bubble_drained", valid, 0);

        // Flush at count 3 with a concurrent write.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 8'h30 + k, 0, 0);
        chk("flush_pre_count", count, 3);
        cycle(1, 8'h99, 1, 1);
        chk("flush_count", count, 0);
        chk("flush_valid", valid, 0);
        chk("flush_sum_empty", sum_empty, 1);
        chk("flush_outdata", outdata, 0);
        chk("flush_overflow", overflow, 0);

        // Flush on a full, stalled chain must not flag overflow.
        for (int k = 0; k < 4; k++) cycle(1, 8'h40 + k, 0, 0);
        drive(1, 8'h77, 1, 0);
        #1;
        chk("flushfull_high_reload", high_reload, 0);
        @(posedge clock);
        #1;
        chk("flushfull_overflow", overflow, 0);
        chk("flushfull_count", count, 0);

        // Asynchronous reset mid-stream.
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) cycle(1, 8'hC0 + k, 0, 1);
        @(negedge clock);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_count", count, 0);
        chk("arst_outdata", outdata, 0);
        chk("arst_sum_empty", sum_empty, 1);
        chk("arst_high_reload", high_reload, 1);
        @(negedge clock);
        rst_n = 1'b1;
        cycle(1, 8'h7E, 0, 1);
        chk("arst_first_write", count, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("arst_not_yet", valid, 0);
        cycle(0, 0, 0, 1);
        chk("arst_valid_7e", valid, 1);
        chk("arst_out_7e", outdata, 8'h7E);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            bit w, f, l;
            int d;
            w = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 1) == 1);
            d = $urandom_range(0, 255);
            drive(w, d, f, l);
            #1;
            check_model();
            @(posedge clock);
            model_step(w, d, f, l);
        end
        @(negedge clock);
        #1;
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter CLEAR_DATA, default 1; 1 zeroes a stage's data when it empties, 0 holds the stale data.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1, upstream write request.
REQ-007 SHALL have port indata, input, DSIZE, upstream write data.
REQ-008 SHALL have port flush, input, 1, synchronous clear of all stages.
REQ-009 SHALL have port low_empty, input, 1, downstream can take the output word this cycle.
REQ-010 SHALL have port high_reload, output, 1, chain can accept a write this cycle.
REQ-011 SHALL have port valid, output, 1, last stage holds a word.
REQ-012 SHALL have port outdata, output, DSIZE, last-stage data.
REQ-013 SHALL have port curr_empty, output, 1, equal to !valid.
REQ-014 SHALL have port sum_empty, output, 1, high when no stage holds a word.
REQ-015 SHALL have port count, output, CW = clog2(DEPTH+1), number of occupied stages.
REQ-016 SHALL have port overflow, output, 1, sticky flag for a write attempted while high_reload=0.

Function
REQ-017 SHALL hold one valid bit vld[i] and one data register data[i] per stage, i=0..DEPTH-1; stage 0 is nearest the input.
REQ-018 SHALL compute the advance signal combinationally: adv[DEPTH-1]=low_empty; adv[i]=!vld[i+1] | adv[i+1].
REQ-019 SHALL set the move enable ld[i]=!vld[i] | adv[i]: stage i may load when it is empty or its word leaves this cycle.
REQ-020 SHALL drive high_reload = ld[0], combinationally; there is no registered lag.
REQ-021 SHALL accept a write when wr_en & high_reload; stage 0 then loads indata and sets vld[0].
REQ-022 SHALL load stage i>0 from stage i-1 when ld[i] & vld[i-1]; otherwise, when ld[i] holds, vld[i] clears.
REQ-023 SHALL keep vld[i] and data[i] unchanged when ld[i]=0.
REQ-024 SHALL zero data[i] when the stage clears and CLEAR_DATA=1.
REQ-025 SHALL consume the output word when valid & low_empty; low_empty with valid=0 SHALL have no effect.
REQ-026 SHALL collapse bubbles: an empty stage is filled even while downstream stalls, so a full chain holds DEPTH words.
REQ-027 SHALL provide latency of DEPTH cycles from an accepted write to valid when unstalled, and throughput of 1 word/cycle.
REQ-028 SHALL preserve word order; no word is ever duplicated or dropped.
REQ-029 SHALL ignore a write when high_reload=0, leave the chain unchanged, and set overflow until reset.
REQ-030 SHALL clear all vld bits and count on flush=1 (zeroing data if CLEAR_DATA=1); flush SHALL win over a simultaneous write or pop, and SHALL NOT set overflow.
REQ-031 SHALL register count: +1 on accepted write only, -1 on pop only, unchanged when both or neither occur; it SHALL never exceed DEPTH.
REQ-032 SHALL accept a write and a pop in the same cycle when the chain is full (high_reload=1 through the adv chain).

Reset
REQ-033 SHALL, while rst_n=0, asynchronously clear all vld, data, count and overflow; outputs SHALL then read valid=0, outdata=0, curr_empty=1, sum_empty=1, count=0, overflow=0, and high_reload=1.
REQ-034 SHALL discard in-flight words when reset is asserted mid-operation, and SHALL accept a write on the first clock edge after release.

Structure
REQ-035 SHALL place the CW width function in the shared package pipe_pkg; no typedefs are required.
REQ-036 SHALL implement one stage as the sub-module pipe_stage (vld/data register, ld and flush inputs, CLEAR_DATA parameter), instantiated DEPTH times with a generate loop.

Verification (DEPTH=4, DSIZE=8)
REQ-037 SHALL cover streaming: write 0x01..0x08 on consecutive cycles with low_empty=1 -> 0x01 on outdata 4 cycles after its write, one word per cycle, count steady at 4.
REQ-038 SHALL cover backpressure: low_empty=0 while writing 0xA0..0xA5 -> exactly 0xA0..0xA3 accepted, high_reload=0, count=4, overflow=1 after 0xA4.
REQ-039 SHALL cover full plus simultaneous write and pop: full chain with low_empty=1 and write 0x55 -> 0x55 accepted, head popped, count stays 4.
REQ-040 SHALL cover bubble collapse: write 0x11, one idle cycle, write 0x22 with low_empty=0 -> both reach stages 3 and 2, count=2.
REQ-041 SHALL cover flush: flush=1 with wr_en=1 and count=3 -> next cycle count=0, valid=0, sum_empty=1, outdata=0, overflow unchanged.
REQ-042 SHALL cover async reset: rst_n low mid-stream between clock edges -> outputs reset immediately; after release, write 0x7E appears 4 cycles later.
